// File: rtl/wb_pattern_master.sv
// Wishbone pattern master: writes a seeded address-derived pattern over a word range,
// reads it back, and reports mismatch count, first failing address and ack timeouts.
module wb_pattern_master #(
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int TIMEOUT = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_resetn,
  input  logic                sdr_init_done,
  input  logic                start,
  input  logic [APP_AW-1:0]   base_addr,
  input  logic [15:0]         num_words,
  input  logic [dw-1:0]       seed,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [15:0]         err_cnt,
  output logic [APP_AW-1:0]   first_err_addr,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [APP_AW-1:0]   wb_addr_o,
  output logic [dw-1:0]       wb_dat_o,
  output logic [dw/8-1:0]     wb_sel_o,
  output logic [2:0]          wb_cti_o,
  input  logic [dw-1:0]       wb_dat_i,
  input  logic                wb_ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [APP_AW-1:0] base_q;
  logic [15:0]       nw_q;
  logic [dw-1:0]     seed_q;
  logic [15:0]       word_cnt;
  logic [TW-1:0]     tmo_cnt;

  logic accept, waiting, ack_ev, tmo_ev, last_word, rd_mismatch;

  // 32-bit base pattern replicated or truncated to dw, then scrambled by the seed.
  function automatic logic [dw-1:0] pattern(input logic [APP_AW-1:0] a,
                                            input logic [dw-1:0]     s);
    logic [31:0]   p32;
    logic [dw-1:0] r;
    p32 = {a[15:0], ~a[15:0]};
    r   = '0;
    for (int i = 0; i < dw; i++) r[i] = p32[i % 32];
    return r ^ s;
  endfunction

  assign accept      = (state == IDLE) && start && sdr_init_done;
  assign waiting     = (state == WR_WAIT) || (state == RD_WAIT);
  assign ack_ev      = waiting && wb_ack_i;
  // An ack arriving on the expiry edge still completes the transfer.
  assign tmo_ev      = waiting && !wb_ack_i && (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_word   = (word_cnt == nw_q - 16'd1);
  assign rd_mismatch = (wb_dat_i != pattern(wb_addr_o, seed_q));
  assign busy        = (state != IDLE);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_resetn) state <= IDLE;
    else            state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (num_words == 16'd0) ? FINISH : WR_REQ;
      WR_REQ:  state_next = WR_WAIT;
      WR_WAIT: if (ack_ev)      state_next = last_word ? RD_REQ : WR_REQ;
               else if (tmo_ev) state_next = FINISH;
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: if (ack_ev)      state_next = last_word ? FINISH : RD_REQ;
               else if (tmo_ev) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_resetn) begin
      done           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_addr_o      <= '0;
      wb_dat_o       <= '0;
      wb_sel_o       <= '0;
      wb_cti_o       <= 3'b111;
      base_q         <= '0;
      nw_q           <= '0;
      seed_q         <= '0;
      word_cnt       <= '0;
      tmo_cnt        <= '0;
    end else begin
      done     <= (state == FINISH);
      wb_cti_o <= 3'b111;
      unique case (state)
        IDLE: begin
          if (accept) begin
            base_q         <= base_addr;
            nw_q           <= num_words;
            seed_q         <= seed;
            wb_addr_o      <= base_addr;
            word_cnt       <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
          end
        end
        WR_REQ, RD_REQ: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= (state == WR_REQ);
          wb_sel_o <= '1;
          tmo_cnt  <= '0;
          if (state == WR_REQ) wb_dat_o <= pattern(wb_addr_o, seed_q);
        end
        WR_WAIT, RD_WAIT: begin
          if (ack_ev) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (last_word) begin
              word_cnt  <= '0;
              wb_addr_o <= base_q;
            end else begin
              word_cnt  <= word_cnt + 16'd1;
              wb_addr_o <= wb_addr_o + APP_AW'(1);
            end
            if (state == RD_WAIT && rd_mismatch) begin
              if (err_cnt == 16'd0)    first_err_addr <= wb_addr_o;
              if (err_cnt != 16'hFFFF) err_cnt        <= err_cnt + 16'd1;
            end
          end else if (tmo_ev) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pattern_master.sv
// Directed bench for wb_pattern_master: a zero-wait memory slave with optional
// read-data corruption, a table of runs, and hand sequences for corner cases.
module tb_wb_pattern_master;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sdr_init_done = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   num_words = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;

  // Slave model state
  logic          slave_en = 1'b1;
  logic          clr_log = 1'b0;
  logic [15:0]   corrupt_mask = '0;
  logic [DW-1:0] mem [64];
  logic [AW-1:0] wr_addr [16];
  logic [DW-1:0] wr_data [16];
  int            wr_n, rd_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_pattern_master #(.dw(DW), .APP_AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_resetn(rst_n), .sdr_init_done(sdr_init_done),
    .start(start), .base_addr(base_addr), .num_words(num_words), .seed(seed),
    .busy(busy), .done(done), .timeout(timeout), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  assign wb_ack_i = slave_en && wb_cyc_o && wb_stb_o;
  assign wb_dat_i = mem[wb_addr_o[5:0]] ^
                    {31'b0, (rd_idx < 16) ? corrupt_mask[rd_idx[3:0]] : 1'b0};

  always @(posedge clk) begin
    if (clr_log) begin
      wr_n   <= 0;
      rd_idx <= 0;
    end else if (wb_ack_i) begin
      if (wb_we_o) begin
        mem[wb_addr_o[5:0]] <= wb_dat_o;
        if (wr_n < 16) begin
          wr_addr[wr_n] <= wb_addr_o;
          wr_data[wr_n] <= wb_dat_o;
        end
        wr_n <= wr_n + 1;
      end else begin
        rd_idx <= rd_idx + 1;
      end
    end
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [DW-1:0] s);
    return {a[15:0], ~a[15:0]} ^ s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [15:0]   nw;
    logic [DW-1:0] seed;
    logic [15:0]   mask;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_first;
    int            exp_cycles;
  } vec_t;

  task automatic clear_log();
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
  endtask

  // Pulses start and returns the number of cycles until done is seen.
  task automatic pulse_start_wait_done(output int cycles);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int            cyc_cnt;
    logic [AW-1:0] a;
    base_addr    = v.base;
    num_words    = v.nw;
    seed         = v.seed;
    corrupt_mask = v.mask;
    clear_log();
    pulse_start_wait_done(cyc_cnt);
    check($sformatf("v%0d start_to_done_cycles", idx), cyc_cnt, v.exp_cycles);
    check($sformatf("v%0d err_cnt", idx), {16'b0, err_cnt}, {16'b0, v.exp_err});
    if (v.exp_err != 16'd0)
      check($sformatf("v%0d first_err_addr", idx), {6'b0, first_err_addr}, {6'b0, v.exp_first});
    check($sformatf("v%0d timeout", idx), {31'b0, timeout}, 32'd0);
    check($sformatf("v%0d write_count", idx), wr_n, {16'b0, v.nw});
    check($sformatf("v%0d read_count", idx), rd_idx, {16'b0, v.nw});
    for (int k = 0; k < v.nw && k < 16; k++) begin
      a = v.base + AW'(k);
      check($sformatf("v%0d wr%0d addr", idx, k), {6'b0, wr_addr[k]}, {6'b0, a});
      check($sformatf("v%0d wr%0d data", idx, k), wr_data[k], pat(a, v.seed));
    end
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), {31'b0, done}, 32'd0);
    check($sformatf("v%0d err_cnt_held", idx), {16'b0, err_cnt}, {16'b0, v.exp_err});
  endtask

  vec_t vecs [5];
  int   cnt;
  bit   seen;

  initial begin
    vecs[0] = '{base: 26'h100, nw: 16'd8, seed: 32'h0, mask: 16'h0,
                exp_err: 16'd0, exp_first: 26'h0, exp_cycles: 34};
    vecs[1] = '{base: 26'h100, nw: 16'd8, seed: 32'hA5A5_1234, mask: 16'h0028,
                exp_err: 16'd2, exp_first: 26'h103, exp_cycles: 34};
    vecs[2] = '{base: 26'h3FF_FFFE, nw: 16'd4, seed: 32'h0, mask: 16'h0,
                exp_err: 16'd0, exp_first: 26'h0, exp_cycles: 18};
    vecs[3] = '{base: 26'h20, nw: 16'd0, seed: 32'h0, mask: 16'h0,
                exp_err: 16'd0, exp_first: 26'h0, exp_cycles: 2};
    vecs[4] = '{base: 26'h3FF_FFFF, nw: 16'd1, seed: 32'hFFFF_FFFF, mask: 16'h0001,
                exp_err: 16'd1, exp_first: 26'h3FF_FFFF, exp_cycles: 6};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst cyc",  {31'b0, wb_cyc_o}, 32'd0);
    check("rst stb",  {31'b0, wb_stb_o}, 32'd0);
    check("rst we",   {31'b0, wb_we_o},  32'd0);
    check("rst busy", {31'b0, busy},     32'd0);
    check("rst done", {31'b0, done},     32'd0);
    check("rst timeout", {31'b0, timeout}, 32'd0);
    check("rst err_cnt", {16'b0, err_cnt}, 32'd0);
    check("rst first_err_addr", {6'b0, first_err_addr}, 32'd0);
    check("rst addr", {6'b0, wb_addr_o}, 32'd0);
    check("rst dat",  wb_dat_o, 32'd0);
    check("rst sel",  {28'b0, wb_sel_o}, 32'd0);
    check("rst cti",  {29'b0, wb_cti_o}, 32'd7);
    rst_n = 1'b1;
    @(negedge clk);

    // start before init completes is ignored
    base_addr = 26'h40;
    num_words = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy || wb_cyc_o) seen = 1'b1;
      @(negedge clk);
    end
    check("noinit busy_or_cyc_seen", {31'b0, seen}, 32'd0);
    sdr_init_done = 1'b1;

    // Table of full runs
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Missing ack: cyc held TIMEOUT cycles, then timeout and done
    slave_en  = 1'b0;
    base_addr = 26'h10;
    num_words = 16'd2;
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!wb_cyc_o && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("tmo cyc_rise_latency", cnt, 1);
    cnt = 0;
    while (wb_cyc_o && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo cyc_high_cycles", cnt, TO);
    check("tmo timeout_set", {31'b0, timeout}, 32'd1);
    check("tmo done_not_yet", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("tmo done_pulse", {31'b0, done}, 32'd1);
    slave_en = 1'b1;
    @(negedge clk);
    check("tmo timeout_sticky", {31'b0, timeout}, 32'd1);
    run_vec(vecs[0], 5);

    // Reset during read 2 of a corrupted run
    base_addr    = 26'h100;
    num_words    = 16'd8;
    seed         = 32'h0;
    corrupt_mask = 16'h0001;
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(wb_cyc_o && !wb_we_o && rd_idx == 2) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("rstmid reached_read2", {31'b0, cnt < 200}, 32'd1);
    check("rstmid err_before", {16'b0, err_cnt}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("rstmid busy", {31'b0, busy}, 32'd0);
    check("rstmid err_cnt", {16'b0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    seen = done;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || wb_cyc_o) seen = 1'b1;
    end
    check("rstmid no_done_no_cyc", {31'b0, seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
